// File: rtl/alu_decode_stage_if.sv
// rtl/alu_decode_stage_if.sv - fetch-side and execute-side handshake bundle of the decode stage
interface alu_decode_stage_if #(
  parameter int XLEN  = 32,
  parameter int SEL_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] alu_sel;
  logic [XLEN-1:0]  imm;
  logic             src1_pc;
  logic             src1_zero;
  logic             src2_imm;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [4:0]       rd;
  logic             reg_we;
  logic             mem_rd;
  logic             mem_wr;
  logic             illegal;

  // Decode stage view
  modport slave (
    input  in_valid, in_inst, flush, out_ready,
    output in_ready, out_valid, alu_sel, imm, src1_pc, src1_zero, src2_imm,
           rs1, rs2, rd, reg_we, mem_rd, mem_wr, illegal
  );

  // Fetch/execute (driver) view
  modport master (
    output in_valid, in_inst, flush, out_ready,
    input  in_ready, out_valid, alu_sel, imm, src1_pc, src1_zero, src2_imm,
           rs1, rs2, rd, reg_we, mem_rd, mem_wr, illegal
  );
endinterface

// File: rtl/alu_decode_stage.sv
// rtl/alu_decode_stage.sv - registered RV32I decode producing ALUSel and operand controls
module alu_decode_stage #(
  parameter int XLEN  = 32,
  parameter int SEL_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  alu_decode_stage_if.slave bus
);
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  localparam logic [SEL_W-1:0] SEL_ADDI  = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_SLTI  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_SLTIU = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_XORI  = SEL_W'(3);
  localparam logic [SEL_W-1:0] SEL_ORI   = SEL_W'(4);
  localparam logic [SEL_W-1:0] SEL_ANDI  = SEL_W'(5);
  localparam logic [SEL_W-1:0] SEL_SLLI  = SEL_W'(6);
  localparam logic [SEL_W-1:0] SEL_SRLI  = SEL_W'(7);
  localparam logic [SEL_W-1:0] SEL_SRAI  = SEL_W'(8);
  localparam logic [SEL_W-1:0] SEL_ADD   = SEL_W'(9);
  localparam logic [SEL_W-1:0] SEL_SUB   = SEL_W'(10);
  localparam logic [SEL_W-1:0] SEL_SLL   = SEL_W'(11);
  localparam logic [SEL_W-1:0] SEL_SLT   = SEL_W'(12);
  localparam logic [SEL_W-1:0] SEL_SLTU  = SEL_W'(13);
  localparam logic [SEL_W-1:0] SEL_XOR   = SEL_W'(14);
  localparam logic [SEL_W-1:0] SEL_SRL   = SEL_W'(15);
  localparam logic [SEL_W-1:0] SEL_SRA   = SEL_W'(16);
  localparam logic [SEL_W-1:0] SEL_OR    = SEL_W'(17);
  localparam logic [SEL_W-1:0] SEL_AND   = SEL_W'(18);

  logic [31:0]      inst;
  logic [6:0]       opcode;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [XLEN-1:0]  imm_i, imm_sh, imm_s, imm_u;

  logic [SEL_W-1:0] d_sel;
  logic [XLEN-1:0]  d_imm;
  logic             d_s1pc, d_s1z, d_s2i, d_we, d_mrd, d_mwr, d_ill;

  logic             out_valid_q;
  logic [SEL_W-1:0] sel_q;
  logic [XLEN-1:0]  imm_q;
  logic             s1pc_q, s1z_q, s2i_q, we_q, mrd_q, mwr_q, ill_q;
  logic [4:0]       rs1_q, rs2_q, rd_q;
  logic             accept;

  assign inst   = bus.in_inst;
  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign imm_i  = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_sh = {{(XLEN-5){1'b0}}, inst[24:20]};
  assign imm_s  = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_u  = {inst[31:12], {(XLEN-20){1'b0}}};

  // Decode the incoming word into the next bundle; illegal encodings collapse to all-zero controls
  always_comb begin
    d_sel  = SEL_ADDI;
    d_imm  = '0;
    d_s1pc = 1'b0;
    d_s1z  = 1'b0;
    d_s2i  = 1'b0;
    d_we   = 1'b0;
    d_mrd  = 1'b0;
    d_mwr  = 1'b0;
    d_ill  = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        d_s2i = 1'b1;
        d_we  = 1'b1;
        d_imm = imm_i;
        case (f3)
          3'b000: d_sel = SEL_ADDI;
          3'b010: d_sel = SEL_SLTI;
          3'b011: d_sel = SEL_SLTIU;
          3'b100: d_sel = SEL_XORI;
          3'b110: d_sel = SEL_ORI;
          3'b111: d_sel = SEL_ANDI;
          3'b001: begin
            d_sel = SEL_SLLI;
            d_imm = imm_sh;
            d_ill = (f7 != 7'b0);
          end
          default: begin
            d_imm = imm_sh;
            if (f7 == 7'b0)        d_sel = SEL_SRLI;
            else if (f7 == F7_ALT) d_sel = SEL_SRAI;
            else                   d_ill = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        d_we = 1'b1;
        if (f7 == 7'b0) begin
          case (f3)
            3'b000:  d_sel = SEL_ADD;
            3'b001:  d_sel = SEL_SLL;
            3'b010:  d_sel = SEL_SLT;
            3'b011:  d_sel = SEL_SLTU;
            3'b100:  d_sel = SEL_XOR;
            3'b101:  d_sel = SEL_SRL;
            3'b110:  d_sel = SEL_OR;
            default: d_sel = SEL_AND;
          endcase
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          d_sel = SEL_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          d_sel = SEL_SRA;
        end else begin
          d_ill = 1'b1;
        end
      end
      OPC_LOAD: begin
        d_imm = imm_i;
        d_s2i = 1'b1;
        d_we  = 1'b1;
        d_mrd = 1'b1;
      end
      OPC_STORE: begin
        d_imm = imm_s;
        d_s2i = 1'b1;
        d_mwr = 1'b1;
      end
      OPC_LUI: begin
        d_imm = imm_u;
        d_s1z = 1'b1;
        d_s2i = 1'b1;
        d_we  = 1'b1;
      end
      OPC_AUIPC: begin
        d_imm  = imm_u;
        d_s1pc = 1'b1;
        d_s2i  = 1'b1;
        d_we   = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_sel  = SEL_ADDI;
      d_imm  = '0;
      d_s1pc = 1'b0;
      d_s1z  = 1'b0;
      d_s2i  = 1'b0;
      d_we   = 1'b0;
      d_mrd  = 1'b0;
      d_mwr  = 1'b0;
    end
  end

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Output register: flush wins, then load on accept, then drain; payload only changes on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sel_q       <= '0;
      imm_q       <= '0;
      s1pc_q      <= 1'b0;
      s1z_q       <= 1'b0;
      s2i_q       <= 1'b0;
      we_q        <= 1'b0;
      mrd_q       <= 1'b0;
      mwr_q       <= 1'b0;
      ill_q       <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      sel_q       <= d_sel;
      imm_q       <= d_imm;
      s1pc_q      <= d_s1pc;
      s1z_q       <= d_s1z;
      s2i_q       <= d_s2i;
      we_q        <= d_we;
      mrd_q       <= d_mrd;
      mwr_q       <= d_mwr;
      ill_q       <= d_ill;
      rs1_q       <= inst[19:15];
      rs2_q       <= inst[24:20];
      rd_q        <= inst[11:7];
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.alu_sel   = sel_q;
  assign bus.imm       = imm_q;
  assign bus.src1_pc   = s1pc_q;
  assign bus.src1_zero = s1z_q;
  assign bus.src2_imm  = s2i_q;
  assign bus.rs1       = rs1_q;
  assign bus.rs2       = rs2_q;
  assign bus.rd        = rd_q;
  assign bus.reg_we    = we_q;
  assign bus.mem_rd    = mrd_q;
  assign bus.mem_wr    = mwr_q;
  assign bus.illegal   = ill_q;
endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Registered decode stage that turns a fetched RV32I instruction word into the 5-bit ALUSel code and operand controls consumed by the combinational ALU.
- It produces the ALUSel encoding the ALU decodes; the ALU sits on the other side of this stage.
- Sits between fetch and execute, with valid/ready handshakes on both sides and a flush input for redirects.

Parameters:
- XLEN, 32, data/immediate width (only 32 supported).
- SEL_W, 5, ALUSel width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  instruction word valid
- in_ready  output  1  stage can accept an instruction
- in_inst  input  32  instruction word
- flush  input  1  discard held and incoming instruction
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  execute accepts the bundle
- alu_sel  output  SEL_W  ALU op code
- imm  output  XLEN  decoded immediate
- src1_pc  output  1  ALU in1 = PC (AUIPC)
- src1_zero  output  1  ALU in1 = 0 (LUI)
- src2_imm  output  1  ALU in2 = imm
- rs1, rs2, rd  output  5 each  register indices (inst[19:15], [24:20], [11:7])
- reg_we  output  1  write rd
- mem_rd  output  1  load
- mem_wr  output  1  store
- illegal  output  1  unsupported encoding

Behaviour:
- ALUSel codes are fixed:
  - 0 ADDI, 1 SLTI, 2 SLTIU, 3 XORI, 4 ORI, 5 ANDI, 6 SLLI, 7 SRLI, 8 SRAI
  - 9 ADD, 10 SUB, 11 SLL, 12 SLT, 13 SLTU, 14 XOR, 15 SRL, 16 SRA, 17 OR, 18 AND
- Opcode decode:
  - 0010011 OP-IMM: codes 0-8 by funct3, src2_imm=1, reg_we=1.
  - 0110011 OP: codes 9-18 by funct3/funct7[5], src2_imm=0, reg_we=1.
  - 0000011 LOAD: alu_sel=0, src2_imm=1, reg_we=1, mem_rd=1.
  - 0100011 STORE: alu_sel=0, src2_imm=1, mem_wr=1.
  - 0110111 LUI: alu_sel=0, src1_zero=1, src2_imm=1, reg_we=1.
  - 0010111 AUIPC: alu_sel=0, src1_pc=1, src2_imm=1, reg_we=1.
- Immediates:
  - I-type: sign-extend inst[31:20]. SLTIU also uses the sign-extended imm (the ALU compares unsigned).
  - Shift-imm: {27'b0, inst[24:20]}.
  - S-type: sign-extend {inst[31:25], inst[11:7]}.
  - U-type: {inst[31:12], 12'b0}.
  - R-type: imm=0.
- Illegal when any of these hold:
  - unknown opcode;
  - OP with funct7 not 0000000/0100000, or funct7=0100000 with funct3 not 000/101;
  - SLLI with funct7≠0;
  - SRxI with funct7 not 0000000/0100000.
- An illegal instruction is still delivered with out_valid=1 and illegal=1. In that case alu_sel=0, imm=0, and reg_we, mem_rd, mem_wr, src1_*, src2_imm are all 0.
- Pipeline is a single output register, latency 1 cycle: the bundle accepted on edge N is visible after edge N.
- in_ready = !out_valid || out_ready. This is combinational and has no dependency on in_valid.
- Transfer on each side happens when valid && ready on the same edge.
- When out_valid=1 and out_ready=0, every output holds stable and in_ready=0. No instruction is dropped or duplicated.
- Simultaneous output drain and input accept on one edge: the register loads the new bundle, out_valid stays 1.
- flush=1 at an edge: out_valid←0 and the incoming instruction is discarded regardless of in_valid. While flush is high, in_ready stays as defined; the handshake is ignored.
- Reset (asynchronous, any time, including mid-stall):
  - out_valid=0, alu_sel=0, imm=0, all flags 0, rs1/rs2/rd=0.
  - in_ready=1 while rst is low after release.
- Outputs other than out_valid are don't-care-free: they hold their last value while out_valid=0 (not X).

Test Plan:
- ADDI x1,x0,5 (0x00500093), out_ready=1 → next cycle: out_valid=1, alu_sel=0, imm=5, rd=1, rs1=0, src2_imm=1, reg_we=1, illegal=0.
- SUB x3,x1,x2 (0x402081B3) → alu_sel=10, rs1=1, rs2=2, rd=3, src2_imm=0, imm=0. SRAI x5,x6,3 (0x40335293) → alu_sel=8, imm=3, rs1=6, rd=5.
- SW x2,-4(x1) (0xFE20AE23) → alu_sel=0, imm=0xFFFFFFFC, mem_wr=1, reg_we=0, rs1=1, rs2=2.
- Backpressure: accept 0x00500093, hold out_ready=0 for 3 cycles while offering 0x402081B3 → in_ready=0, outputs frozen at the ADDI bundle. Raise out_ready → ADDI consumed, SUB bundle appears next cycle, no loss or duplicate.
- Illegal 0x0000007F, then 0x002081B3 with funct7=0000001 (0x022081B3) → both produce out_valid=1, illegal=1, reg_we=0, alu_sel=0.
- Flush and reset: with a bundle held under stall, pulse flush → out_valid=0 next edge and the concurrent input is dropped. Assert rst asynchronously mid-stall → out_valid=0 and all outputs zero immediately, without waiting for a clock edge. in_ready=1 after release.
